seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
Parametrised, self-sequencing successor to the hand-driven Simple RISC datapath. It contains a register file, A/B/C pipeline registers, a shifter, an ALU and a status register. A single `start` pulse with instruction fields runs the whole read-A / read-B / execute / write-back sequence internally, and `done` reports completion. It sits between the future instruction decoder and the register/ALU resources, so the controller no longer toggles loada/loadb/loadc/asel/bsel itself.

Parameters:
WIDTH, 16, datapath word width (>= 8).
NREGS, 8, number of general registers (power of 2, >= 2).
AW (localparam), $clog2(NREGS), register index width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  request an operation; sampled only when ready=1
rn  in  AW  A-operand register index
rm  in  AW  B-operand register index
rd  in  AW  destination register index
ALUop  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 MVN (~B)
shift  in  2  B-operand shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
use_imm  in  1  B operand = sign-extended datapath_in[4:0] instead of shifted R[rm]
zero_a  in  1  A operand forced to 0
wb_en  in  1  write result back to R[rd]
ld_en  in  1  direct load R[ld_num] <= datapath_in; honoured only in IDLE and when start=0
ld_num  in  AW  direct-load index
datapath_in  in  WIDTH  direct-load data / immediate source
ready  out  1  high in IDLE or WB (start accepted)
done  out  1  high for exactly the WB cycle
datapath_out  out  WIDTH  C register
status_out  out  3  {V,N,Z}

Behaviour:
- Reset (asynchronous) clears all of the following to 0: state=IDLE, A, B, C, status, every register, and any latched fields. Outputs after reset: ready=1, done=0. Reset mid-operation aborts the operation with no write-back.
- At an accepting edge (start=1, ready=1), latch rn, rm, rd, ALUop, shift, use_imm, zero_a, wb_en and imm=datapath_in[4:0]. Later changes to these inputs are ignored.
- State machine without the optional feature: IDLE -> RD_A -> RD_B -> EXEC -> WB.
  - RD_A edge: A <= R[rn].
  - RD_B edge: B <= R[rm].
  - EXEC edge: C <= ALU result and status <= flags.
  - WB edge: R[rd] <= C if wb_en.
- Leaving WB: go to RD_A if start=1, else IDLE.
- Latency: done is high in the 4th cycle after the accepting edge. Write-back occurs at the edge that ends WB. Back-to-back throughput is 1 op per 4 cycles.
- A RAW hazard on back-to-back ops needs no forwarding: the next RD_A read occurs after the write-back edge.
- Operand formation:
  - Ain = zero_a ? 0 : A.
  - Bin = use_imm ? sext(imm) : shift(B).
  - The shift applies only when use_imm=0.
- ALU arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/MVN.
- C and status hold their values outside EXEC.
- Direct load: ld_en in IDLE with start=0 writes at the edge. ld_en is ignored in every other state. When ld_en and start are both high in IDLE, start wins and the load is dropped.

Optional Feature:
Macro SEQ_DP_DUAL_READ_EN.
- Defined: the register file has two read ports. The sequence is IDLE -> RD_AB -> EXEC -> WB, with A and B loaded at the same edge. done is high in the 3rd cycle after acceptance, and throughput is 1 op per 3 cycles.
- Undefined: single read port and the 4-state sequence above.
- All other behaviour is identical in both builds.

Decomposition:
- Package seq_dp_pkg holds:
  - the state enum (IDLE, RD_A, RD_B, RD_AB, EXEC, WB);
  - ALUop codes;
  - shift codes;
  - IMM_W=5.
- Sub-module seq_dp_regfile (WIDTH, NREGS) provides 1 synchronous write port with asynchronous clear on reset, and 1 or 2 combinational read ports depending on the macro.
- The shifter and ALU stay inline as combinational functions.

Test Plan:
All scenarios use WIDTH=16 and NREGS=8.
1. Load R0=7 and R1=2. Start ADD rd=2, rn=1, rm=0, shift=LSL1, wb_en=1 -> done in cycle 4 (3 with macro), datapath_out=16, R2=16, status=000.
2. Start SUB rn=rm=0 with R0=7 -> C=0, status=001 (Z). With wb_en=0, R0 is unchanged.
3. Load R3=0x7FFF and R4=0x0001. ADD rn=3, rm=4 -> C=0x8000, status=110 (V,N).
4. R1=2, use_imm=1, datapath_in[4:0]=5'b11111. ADD rn=1 -> C=0x0001. Separately, zero_a=1 with MVN of rm=0 where R0=7 -> C=0xFFF8, N=1.
5. Back-to-back: hold start through WB. Op1 ADD rd=5 (R0+R1=9), then op2 ADD rn=5, rm=5 -> second result 18, no idle cycle between done and the next RD_A. ld_en pulsed while busy -> no register change.
6. Assert reset during EXEC of a wb_en op to rd=6 -> R6=0, datapath_out=0, status=000, ready=1 immediately (asynchronous).

Source files
------------

// File: rtl/seq_dp_pkg.sv
// seq_dp_pkg: shared state, ALU-op and shift encodings for the self-sequencing datapath.
package seq_dp_pkg;
    localparam int IMM_W = 5;
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_AB, EXEC, WB} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN} alu_op_t;
    typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_t;
endpackage

// File: rtl/seq_dp_regfile.sv
// seq_dp_regfile: register file, one sync write port, async clear, combinational reads.
// SEQ_DP_DUAL_READ_EN adds a second read port.
module seq_dp_regfile
    import seq_dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a
`ifdef SEQ_DP_DUAL_READ_EN
    ,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
`endif
);
    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
`ifdef SEQ_DP_DUAL_READ_EN
    assign rdata_b = regs[raddr_b];
`endif
endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: start-driven read/execute/write-back sequencer around regfile, shifter and ALU.
// SEQ_DP_DUAL_READ_EN reads A and B in one cycle (3-cycle op instead of 4).
module seq_datapath
    import seq_dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    input  logic [AW-1:0]    rd,
    input  logic [1:0]       ALUop,
    input  logic [1:0]       shift,
    input  logic             use_imm,
    input  logic             zero_a,
    input  logic             wb_en,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_num,
    input  logic [WIDTH-1:0] datapath_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       status_out
);
`ifdef SEQ_DP_DUAL_READ_EN
    localparam state_t FIRST = RD_AB;
`else
    localparam state_t FIRST = RD_A;
`endif

    state_t state, next;
    logic [AW-1:0] rn_q, rm_q, rd_q, raddr_a, waddr;
    alu_op_t op_q;
    shift_t sh_q;
    logic [IMM_W-1:0] imm_q;
    logic imm_sel_q, zero_a_q, wb_q, accept, we, v;
    logic [WIDTH-1:0] a_q, b_q, c_q, rdata_a, wdata, ain, bin, sum, diff, res;
    logic [2:0] st_q;

    function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] b, input shift_t s);
        return s == SH_LSL1 ? {b[WIDTH-2:0], 1'b0} :
               s == SH_LSR1 ? {1'b0, b[WIDTH-1:1]} :
               s == SH_ASR1 ? {b[WIDTH-1], b[WIDTH-1:1]} : b;
    endfunction

    assign ready  = state == IDLE || state == WB;
    assign done   = state == WB;
    assign accept = start && ready;
    // A load request coinciding with start is dropped: start wins.
    assign we    = (state == WB && wb_q) || (state == IDLE && ld_en && !start);
    assign waddr = state == WB ? rd_q : ld_num;
    assign wdata = state == WB ? c_q : datapath_in;

`ifdef SEQ_DP_DUAL_READ_EN
    logic [WIDTH-1:0] rdata_b;
    assign raddr_a = rn_q;
    seq_dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(rm_q), .rdata_b(rdata_b)
    );
`else
    assign raddr_a = state == RD_A ? rn_q : rm_q;
    seq_dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a)
    );
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:        if (start) next = FIRST;
            RD_A:        next = RD_B;
            RD_B, RD_AB: next = EXEC;
            EXEC:        next = WB;
            WB:          next = start ? FIRST : IDLE;
            default:     next = IDLE;
        endcase
    end

    always_comb begin
        ain  = zero_a_q ? '0 : a_q;
        bin  = imm_sel_q ? {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q} : shift_b(b_q, sh_q);
        sum  = ain + bin;
        diff = ain - bin;
        res  = op_q == ALU_ADD ? sum : op_q == ALU_SUB ? diff : op_q == ALU_AND ? ain & bin : ~bin;
        v    = op_q == ALU_ADD ? (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]) :
               op_q == ALU_SUB ? (ain[WIDTH-1] != bin[WIDTH-1]) && (diff[WIDTH-1] != ain[WIDTH-1]) : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {rn_q, rm_q, rd_q, imm_q, imm_sel_q, zero_a_q, wb_q} <= '0;
            op_q <= ALU_ADD;
            sh_q <= SH_NONE;
            {a_q, b_q, c_q, st_q} <= '0;
        end else begin
            if (accept) begin
                {rn_q, rm_q, rd_q} <= {rn, rm, rd};
                op_q      <= alu_op_t'(ALUop);
                sh_q      <= shift_t'(shift);
                imm_q     <= datapath_in[IMM_W-1:0];
                imm_sel_q <= use_imm;
                zero_a_q  <= zero_a;
                wb_q      <= wb_en;
            end
            if (state == RD_A || state == RD_AB) a_q <= rdata_a;
`ifdef SEQ_DP_DUAL_READ_EN
            if (state == RD_AB) b_q <= rdata_b;
`else
            if (state == RD_B) b_q <= rdata_a;
`endif
            if (state == EXEC) begin
                c_q  <= res;
                st_q <= {v, res[WIDTH-1], res == '0};
            end
        end
    end

    assign datapath_out = c_q;
    assign status_out   = st_q;
endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed ops with hand-computed results checked by a done-driven scoreboard.
module tb_seq_datapath;
    import seq_dp_pkg::*;
`ifdef SEQ_DP_DUAL_READ_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 4;
`endif

    typedef struct packed {
        logic [15:0] c;
        logic [2:0]  s;
    } exp_t;

    logic clk = 0, reset = 1, start = 0, use_imm = 0, zero_a = 0, wb_en = 0, ld_en = 0;
    logic [2:0] rn = 0, rm = 0, rd = 0, ld_num = 0;
    logic [1:0] ALUop = 0, shift = 0;
    logic [15:0] datapath_in = 0, datapath_out;
    logic ready, done;
    logic [2:0] status_out;
    exp_t exp_q[$];
    int tag_q[$];
    int n_cmp = 0, n_err = 0;
    int lat;

    seq_datapath #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
        .ALUop(ALUop), .shift(shift), .use_imm(use_imm), .zero_a(zero_a), .wb_en(wb_en),
        .ld_en(ld_en), .ld_num(ld_num), .datapath_in(datapath_in), .ready(ready), .done(done),
        .datapath_out(datapath_out), .status_out(status_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        int t;
        if (!reset && done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: out=%h status=%b with empty scoreboard", datapath_out, status_out);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (datapath_out !== e.c || status_out !== e.s) begin
                    n_err++;
                    $display("FAIL op%0d: got out=%h status=%b, want out=%h status=%b",
                             t, datapath_out, status_out, e.c, e.s);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push(input int tag, input logic [15:0] c, input logic [2:0] s);
        exp_t e;
        e.c = c;
        e.s = s;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic load(input logic [2:0] idx, input logic [15:0] val);
        ld_num = idx;
        datapath_in = val;
        ld_en = 1;
        @(posedge clk); #1;
        ld_en = 0;
    endtask

    task automatic op(input int tag, input logic [1:0] aop, input logic [1:0] sh,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                      input logic imm, input logic za, input logic wb, input logic [15:0] din,
                      input logic ld, input logic [15:0] ec, input logic [2:0] es);
        int n;
        {rn, rm, rd, ALUop, shift} = {a, b, d, aop, sh};
        {use_imm, zero_a, wb_en} = {imm, za, wb};
        datapath_in = din;
        ld_en = ld;
        ld_num = 3'd4;
        start = 1;
        push(tag, ec, es);
        @(posedge clk); #1;
        start = 0;
        ld_en = 0;
        // Scramble inputs to prove the accepted fields were latched.
        {rn, rm, rd, ALUop, shift} = ~{a, b, d, aop, sh};
        {use_imm, zero_a, wb_en} = ~{imm, za, wb};
        datapath_in = ~din;
        wait_done(n);
        chk($sformatf("latency_op%0d", tag), n, LAT);
        @(posedge clk); #1;
    endtask

    task automatic readback(input int tag, input logic [2:0] idx, input logic [15:0] val);
        op(tag, ALU_ADD, SH_NONE, idx, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,
           val, {1'b0, val[15], val == 16'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_out", datapath_out, 0);
        chk("reset_status", status_out, 0);

        load(0, 16'd7);
        load(1, 16'd2);
        op(1, ALU_ADD, SH_LSL1, 1, 0, 2, 0, 0, 1, 16'h0, 0, 16'd16, 3'b000);
        readback(2, 2, 16'd16);
        op(3, ALU_SUB, SH_NONE, 0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0000, 3'b001);
        readback(4, 0, 16'd7);
        load(3, 16'h7FFF);
        load(4, 16'h0001);
        op(5, ALU_ADD, SH_NONE, 3, 4, 0, 0, 0, 0, 16'h1234, 1, 16'h8000, 3'b110);
        readback(6, 4, 16'h0001);
        op(7, ALU_ADD, SH_NONE, 1, 0, 0, 1, 0, 0, 16'hFFFF, 0, 16'h0001, 3'b000);
        op(8, ALU_MVN, SH_NONE, 0, 0, 0, 0, 1, 0, 16'h0, 0, 16'hFFF8, 3'b010);
        load(7, 16'h8002);
        op(9, ALU_ADD, SH_LSR1, 0, 7, 0, 0, 1, 0, 16'h0, 0, 16'h4001, 3'b000);
        op(10, ALU_ADD, SH_ASR1, 0, 7, 0, 0, 1, 0, 16'h0, 0, 16'hC001, 3'b010);
        op(11, ALU_AND, SH_NONE, 3, 7, 0, 0, 0, 0, 16'h0, 0, 16'h0002, 3'b000);
        op(12, ALU_SUB, SH_NONE, 3, 7, 0, 0, 0, 0, 16'h0, 0, 16'hFFFD, 3'b110);
        op(13, ALU_SUB, SH_LSL1, 1, 7, 0, 1, 0, 0, 16'h0005, 0, 16'hFFFD, 3'b010);

        {rn, rm, rd, ALUop, shift} = {3'd0, 3'd1, 3'd5, ALU_ADD, SH_NONE};
        {use_imm, zero_a, wb_en} = 3'b001;
        start = 1;
        push(20, 16'd9, 3'b000);
        push(21, 16'd18, 3'b000);
        @(posedge clk); #1;
        {rn, rm, rd, wb_en} = {3'd5, 3'd5, 3'd6, 1'b0};
        {ld_en, ld_num, datapath_in} = {1'b1, 3'd1, 16'hAAAA};
        wait_done(lat);
        chk("b2b_first_latency", lat, LAT);
        @(posedge clk); #1;
        start = 0;
        ld_en = 0;
        wait_done(lat);
        chk("b2b_done_spacing", lat, LAT);
        @(posedge clk); #1;
        readback(22, 5, 16'd9);
        readback(23, 1, 16'd2);

        op(24, ALU_MVN, SH_NONE, 0, 0, 0, 0, 1, 0, 16'h0, 0, 16'hFFF8, 3'b010);
        load(6, 16'h0055);
        {rn, rm, rd, ALUop, shift} = {3'd1, 3'd0, 3'd6, ALU_ADD, SH_NONE};
        {use_imm, zero_a, wb_en} = 3'b001;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (LAT - 2) @(posedge clk);
        #2 reset = 1;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_out", datapath_out, 0);
        chk("abort_status", status_out, 0);
        @(posedge clk); #1;
        reset = 0;
        readback(25, 6, 16'h0000);
        readback(26, 0, 16'h0000);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
